// File: rtl/arb_rsp_router.sv
// Response-return router: remembers which requester won each issued request
// and steers the single downstream response stream back to it, in issue order.
module arb_rsp_router #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      issue_valid_i,
    input  logic [NUM_PORTS-1:0]      issue_gnt_i,
    output logic                      issue_ready_o,
    input  logic                      rsp_valid_i,
    input  logic [DATA_W-1:0]         rsp_data_i,
    output logic                      rsp_ready_o,
    output logic [NUM_PORTS-1:0]      port_rsp_valid_o,
    output logic [DATA_W-1:0]         port_rsp_data_o,
    input  logic [NUM_PORTS-1:0]      port_rsp_ready_i,
    output logic [$clog2(DEPTH):0]    outstanding_o,
    output logic                      err_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_onehot;
    logic             issue_fire;
    logic             push;
    logic             bad_gnt;
    logic [IDX_W-1:0] head;
    logic             pop;
    logic             spurious;

    // Pointers carry a wrap bit: equal means empty, differing only in the
    // wrap bit means full.
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (issue_gnt_i[k]) begin
                gnt_idx = IDX_W'(k);
            end
        end
    end

    assign gnt_onehot = (issue_gnt_i != '0) &&
                        ((issue_gnt_i & (issue_gnt_i - NUM_PORTS'(1))) == '0);

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high. issue_ready_o depends only on registered fullness, so a pop never
    // frees a slot for an issue in the same cycle.
    assign issue_ready_o = !full;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign push          = issue_fire && gnt_onehot;
    assign bad_gnt       = issue_fire && !gnt_onehot;

    assign head = mem[rd_ptr[AW-1:0]];

    always_comb begin
        port_rsp_valid_o = '0;
        rsp_ready_o      = 1'b1;
        if (!empty) begin
            port_rsp_valid_o[head] = rsp_valid_i;
            rsp_ready_o            = port_rsp_ready_i[head];
        end
    end

    assign pop             = !empty && rsp_valid_i && rsp_ready_o;
    assign spurious        = empty && rsp_valid_i;
    assign port_rsp_data_o = rsp_data_i;
    assign outstanding_o   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (bad_gnt || spurious) begin
                err_o <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_arb_rsp_router.sv
// Self-checking bench for arb_rsp_router: queue-based reference model plus a
// scoreboard monitor that checks every routed response against issue order.
module tb_arb_rsp_router;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int OW        = $clog2(DEPTH) + 1;
    localparam int EW        = 8 + DATA_W;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 issue_valid_i = 1'b0;
    logic [NUM_PORTS-1:0] issue_gnt_i = '0;
    logic                 issue_ready_o;
    logic                 rsp_valid_i = 1'b0;
    logic [DATA_W-1:0]    rsp_data_i = '0;
    logic                 rsp_ready_o;
    logic [NUM_PORTS-1:0] port_rsp_valid_o;
    logic [DATA_W-1:0]    port_rsp_data_o;
    logic [NUM_PORTS-1:0] port_rsp_ready_i = '0;
    logic [OW-1:0]        outstanding_o;
    logic                 err_o;

    arb_rsp_router #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .issue_valid_i    (issue_valid_i),
        .issue_gnt_i      (issue_gnt_i),
        .issue_ready_o    (issue_ready_o),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_data_i       (rsp_data_i),
        .rsp_ready_o      (rsp_ready_o),
        .port_rsp_valid_o (port_rsp_valid_o),
        .port_rsp_data_o  (port_rsp_data_o),
        .port_rsp_ready_i (port_rsp_ready_i),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: port indices of outstanding issues, oldest first.
    int                model_q[$];
    bit                model_err = 1'b0;
    bit                rsp_pending = 1'b0;
    logic [DATA_W-1:0] pending_data = '0;
    logic [EW-1:0]     exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_PORTS-1:0] rand_onehot();
        return NUM_PORTS'(1) << $urandom_range(NUM_PORTS - 1, 0);
    endfunction

    // Checks the cycle's outputs against the model, then advances the model
    // by what the upcoming clock edge should do.
    task automatic tick();
        int                   sz;
        int                   head;
        int                   idx;
        logic [NUM_PORTS-1:0] exp_pv;
        bit                   pop;
        bit                   accept;
        @(negedge clk);
        sz     = model_q.size();
        head   = (sz != 0) ? model_q[0] : 0;
        exp_pv = '0;
        if (sz != 0 && rsp_valid_i) exp_pv[head] = 1'b1;
        check("outstanding", 32'(outstanding_o), sz);
        check("issue_ready", 32'(issue_ready_o), 32'(sz < DEPTH));
        check("err", 32'(err_o), 32'(model_err));
        check("rsp_ready", 32'(rsp_ready_o), (sz == 0) ? 1 : 32'(port_rsp_ready_i[head]));
        check("port_valid", 32'(port_rsp_valid_o), 32'(exp_pv));
        pop    = (sz != 0) && rsp_valid_i && port_rsp_ready_i[head];
        accept = issue_valid_i && (sz < DEPTH);
        if (sz == 0 && rsp_valid_i) model_err = 1'b1;
        if (pop) begin
            void'(model_q.pop_front());
            rsp_pending = 1'b0;
        end
        if (accept) begin
            if ($countones(issue_gnt_i) == 1) begin
                idx = 0;
                for (int k = 0; k < NUM_PORTS; k++) if (issue_gnt_i[k]) idx = k;
                model_q.push_back(idx);
            end else begin
                model_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // A response stays presented with the same data until it is consumed.
    task automatic drive(input logic iv, input logic [NUM_PORTS-1:0] gnt, input logic rv,
                         input logic [DATA_W-1:0] d, input logic [NUM_PORTS-1:0] pr);
        logic [DATA_W-1:0] dd;
        dd = (rv && rsp_pending) ? pending_data : d;
        issue_valid_i    = iv;
        issue_gnt_i      = gnt;
        rsp_valid_i      = rv;
        rsp_data_i       = dd;
        port_rsp_ready_i = pr;
        if (rv && model_q.size() != 0 && !rsp_pending) begin
            exp_q.push_back({8'(model_q[0]), dd});
            rsp_pending  = 1'b1;
            pending_data = dd;
        end
        tick();
    endtask

    // Mid-cycle asynchronous reset; the DUT must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_outstanding", 32'(outstanding_o), 0);
        check("rst_port_valid", 32'(port_rsp_valid_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_issue_ready", 32'(issue_ready_o), 1);
        check("rst_rsp_ready", 32'(rsp_ready_o), 1);
        model_q.delete();
        exp_q.delete();
        rsp_pending = 1'b0;
        model_err   = 1'b0;
        rsp_valid_i = 1'b0;
        issue_valid_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) begin
            drive(1'b0, '0, 1'b1, DATA_W'($urandom), '1);
        end
        drive(1'b0, '0, 1'b0, '0, '1);
        check("drained", 32'(model_q.size()), 0);
    endtask

    // Scoreboard monitor: every routed response must match the oldest expected one.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && port_rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(port_rsp_valid_o), 0);
                end else begin
                    e = exp_q[0];
                    check("route_port", 32'(port_rsp_valid_o),
                          32'(NUM_PORTS'(1) << e[EW-1:DATA_W]));
                    check("route_data", 32'(port_rsp_data_o), 32'(e[DATA_W-1:0]));
                    if ((port_rsp_valid_o & port_rsp_ready_i) != '0) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NUM_PORTS-1:0] g;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Spurious response while empty
        drive(1'b0, '0, 1'b1, 8'hA5, '0);
        drive(1'b0, '0, 1'b0, '0, '1);
        do_reset();

        // In-order routing
        drive(1'b1, 4'b0100, 1'b0, '0, '1);
        drive(1'b1, 4'b0001, 1'b0, '0, '1);
        drive(1'b1, 4'b1000, 1'b0, '0, '1);
        drive(1'b0, '0, 1'b1, 8'h11, '1);
        drive(1'b0, '0, 1'b1, 8'h22, '1);
        drive(1'b0, '0, 1'b1, 8'h33, '1);
        drive(1'b0, '0, 1'b0, '0, '1);

        // Backpressure on head port 2
        drive(1'b1, 4'b0100, 1'b0, '0, '1);
        repeat (3) drive(1'b0, '0, 1'b1, 8'h5C, 4'b1011);
        drive(1'b0, '0, 1'b1, 8'h5C, 4'b1111);
        drive(1'b0, '0, 1'b0, '0, '1);

        // Full, then pop with an issue held across the full cycle
        repeat (DEPTH) drive(1'b1, rand_onehot(), 1'b0, '0, '1);
        drive(1'b0, '0, 1'b0, '0, '1);
        g = rand_onehot();
        drive(1'b1, g, 1'b1, DATA_W'($urandom), '1);
        drive(1'b1, g, 1'b0, '0, '1);
        drive(1'b0, '0, 1'b0, '0, '1);
        drain();

        // Bad grants
        drive(1'b1, 4'b0110, 1'b0, '0, '1);
        drive(1'b1, 4'b0000, 1'b0, '0, '1);
        drive(1'b0, '0, 1'b0, '0, '1);

        // Ten push/pop pairs across the pointer wrap
        drive(1'b1, rand_onehot(), 1'b0, '0, '1);
        repeat (9) drive(1'b1, rand_onehot(), 1'b1, DATA_W'($urandom), '1);
        drive(1'b0, '0, 1'b1, DATA_W'($urandom), '1);
        drive(1'b0, '0, 1'b0, '0, '1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            logic                 iv;
            logic                 rv;
            logic [NUM_PORTS-1:0] gnt;
            iv  = 1'($urandom_range(1, 0));
            gnt = ($urandom_range(15, 0) == 0) ? NUM_PORTS'($urandom) : rand_onehot();
            rv  = rsp_pending ? 1'b1 : ($urandom_range(2, 0) != 0);
            drive(iv, gnt, rv, DATA_W'($urandom), NUM_PORTS'($urandom));
        end
        drain();

        // Reset with three outstanding and a stalled response on the bus
        repeat (3) drive(1'b1, rand_onehot(), 1'b0, '0, '1);
        drive(1'b0, '0, 1'b1, 8'h77, '0);
        do_reset();
        drive(1'b0, '0, 1'b1, 8'h3C, '1);
        drive(1'b0, '0, 1'b0, '0, '1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
